// File: rtl/wb_tlc_pkg.sv
// Shared constants for the TLC Wishbone target completion path.
package wb_tlc_pkg;

    localparam logic [1:0] FMT_CPL  = 2'b00;
    localparam logic [1:0] FMT_CPLD = 2'b10;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HDR  = 2'd2,
        LAST = 2'd3
    } cpl_state_t;

    // Wishbone little-endian lane to PCIe byte order.
    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/wb_tlc_bytecnt.sv
// Maps a completion's first byte enables to its byte count and lower address bits.
module wb_tlc_bytecnt (
    input  logic [3:0] first_be,
    output logic [2:0] byte_count,
    output logic [1:0] la
);

    always_comb begin
        byte_count = 3'd1;
        casez (first_be)
            4'b1??1:                   byte_count = 3'd4;
            4'b01?1, 4'b1?10:          byte_count = 3'd3;
            4'b0011, 4'b0110, 4'b1100: byte_count = 3'd2;
            default:                   byte_count = 3'd1;
        endcase
    end

    // Offset of the lowest enabled byte; no enables reads as offset 0.
    always_comb begin
        la = 2'b00;
        casez (first_be)
            4'b???1: la = 2'b00;
            4'b??10: la = 2'b01;
            4'b?100: la = 2'b10;
            4'b1000: la = 2'b11;
            default: la = 2'b00;
        endcase
    end

endmodule

// File: rtl/wb_tlc_cpl.sv
// Completion TLP generator: captures a finished Wishbone read and streams a
// 3-DW-header Cpl/CplD to the PCIe transmit interface in two 64-bit beats.
module wb_tlc_cpl
    import wb_tlc_pkg::*;
#(
    parameter int c_DATA_WIDTH = 64
) (
    input  logic                    wb_clk,
    input  logic                    rst,
    input  logic                    cpl_req,
    input  logic [23:0]             tran_id,
    input  logic [9:0]              tran_length,
    input  logic [7:0]              tran_be,
    input  logic [4:0]              tran_addr,
    input  logic [2:0]              tran_tc,
    input  logic [1:0]              tran_attr,
    input  logic [c_DATA_WIDTH-1:0] rd_data,
    input  logic [15:0]             completer_id,
    input  logic                    tx_rdy,
    output logic                    tx_req,
    output logic [c_DATA_WIDTH-1:0] tx_data,
    output logic                    tx_st,
    output logic                    tx_end,
    output logic                    tx_dwen,
    output logic                    cpl_busy,
    output logic                    cpl_ovf
);

    cpl_state_t  state;
    logic [23:0] id_q;
    logic [9:0]  len_q;
    logic [3:0]  fbe_q;
    logic [4:0]  addr_q;
    logic [2:0]  tc_q;
    logic [1:0]  attr_q;
    logic [31:0] data_q;
    logic [15:0] cid_q;

    logic [2:0]  bc;
    logic [1:0]  la;
    logic        is_cpld;
    logic [11:0] bc12;
    logic [31:0] dw0, dw1, dw2;
    logic [63:0] beat0, beat1;

    // Last-DW enables play no part in a single-DW completion.
    logic unused_last_be;
    assign unused_last_be = ^tran_be[3:0];

    wb_tlc_bytecnt u_bytecnt (
        .first_be   (fbe_q),
        .byte_count (bc),
        .la         (la)
    );

    // Only single-DW reads complete with data; anything else is Unsupported Request.
    assign is_cpld = (len_q == 10'd1);
    assign bc12    = is_cpld ? {9'd0, bc} : 12'd4;
    assign dw0     = {1'b0, (is_cpld ? FMT_CPLD : FMT_CPL), TYPE_CPL, 1'b0, tc_q,
                      4'b0, 2'b0, attr_q, 2'b0, (is_cpld ? len_q : 10'd0)};
    assign dw1     = {cid_q, (is_cpld ? CPL_SC : CPL_UR), 1'b0, bc12};
    assign dw2     = {id_q, 1'b0, addr_q, la};
    assign beat0   = {dw0, dw1};
    assign beat1   = {dw2, (is_cpld ? data_q : 32'h0)};

    always_ff @(posedge wb_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_req   <= 1'b0;
            tx_data  <= '0;
            tx_st    <= 1'b0;
            tx_end   <= 1'b0;
            tx_dwen  <= 1'b0;
            cpl_busy <= 1'b0;
            cpl_ovf  <= 1'b0;
            id_q     <= '0;
            len_q    <= '0;
            fbe_q    <= '0;
            addr_q   <= '0;
            tc_q     <= '0;
            attr_q   <= '0;
            data_q   <= '0;
            cid_q    <= '0;
        end else begin
            if (cpl_req && state != IDLE)
                cpl_ovf <= 1'b1;
            case (state)
                IDLE: if (cpl_req) begin
                    state    <= REQ;
                    tx_req   <= 1'b1;
                    cpl_busy <= 1'b1;
                    id_q     <= tran_id;
                    len_q    <= tran_length;
                    fbe_q    <= tran_be[7:4];
                    addr_q   <= tran_addr;
                    tc_q     <= tran_tc;
                    attr_q   <= tran_attr;
                    cid_q    <= completer_id;
                    data_q   <= bswap32(tran_addr[0] ? rd_data[63:32] : rd_data[31:0]);
                end
                REQ: if (tx_rdy) begin
                    state   <= HDR;
                    tx_st   <= 1'b1;
                    tx_data <= beat0;
                end
                HDR: if (tx_rdy) begin
                    state   <= LAST;
                    tx_req  <= 1'b0;
                    tx_st   <= 1'b0;
                    tx_end  <= 1'b1;
                    tx_dwen <= ~is_cpld;
                    tx_data <= beat1;
                end
                LAST: if (tx_rdy) begin
                    state    <= IDLE;
                    tx_end   <= 1'b0;
                    tx_dwen  <= 1'b0;
                    tx_data  <= '0;
                    cpl_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_tlc_cpl.sv
// Directed bench for wb_tlc_cpl with hand-computed completion beats.
module tb_wb_tlc_cpl;

    logic        wb_clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpl_req = 1'b0;
    logic [23:0] tran_id = '0;
    logic [9:0]  tran_length = '0;
    logic [7:0]  tran_be = '0;
    logic [4:0]  tran_addr = '0;
    logic [2:0]  tran_tc = '0;
    logic [1:0]  tran_attr = '0;
    logic [63:0] rd_data = '0;
    logic [15:0] completer_id = '0;
    logic        tx_rdy = 1'b0;
    logic        tx_req;
    logic [63:0] tx_data;
    logic        tx_st, tx_end, tx_dwen, cpl_busy, cpl_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int st_cnt = 0;
    int end_cnt = 0;

    wb_tlc_cpl #(.c_DATA_WIDTH(64)) dut (
        .wb_clk       (wb_clk),
        .rst          (rst),
        .cpl_req      (cpl_req),
        .tran_id      (tran_id),
        .tran_length  (tran_length),
        .tran_be      (tran_be),
        .tran_addr    (tran_addr),
        .tran_tc      (tran_tc),
        .tran_attr    (tran_attr),
        .rd_data      (rd_data),
        .completer_id (completer_id),
        .tx_rdy       (tx_rdy),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_st        (tx_st),
        .tx_end       (tx_end),
        .tx_dwen      (tx_dwen),
        .cpl_busy     (cpl_busy),
        .cpl_ovf      (cpl_ovf)
    );

    always #5 wb_clk = ~wb_clk;

    // Accepted beats: a marked beat on a cycle the core grants.
    always @(posedge wb_clk) begin
        if (tx_st && tx_rdy)  st_cnt  <= st_cnt + 1;
        if (tx_end && tx_rdy) end_cnt <= end_cnt + 1;
    end

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    // One-cycle cpl_req; returns in the following cycle.
    task automatic issue(input logic [9:0] len, input logic [7:0] be, input logic [4:0] addr,
                         input logic [23:0] id, input logic [63:0] d, input logic [15:0] cid,
                         input logic [2:0] tc, input logic [1:0] attr);
        tran_length = len; tran_be = be; tran_addr = addr; tran_id = id;
        rd_data = d; completer_id = cid; tran_tc = tc; tran_attr = attr;
        cpl_req = 1'b1;
        tick();
        cpl_req = 1'b0;
    endtask

    // ctl = {tx_req, tx_st, tx_end, tx_dwen, cpl_busy}
    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_cmp++;
        if ({tx_req, tx_st, tx_end, tx_dwen, cpl_busy, cpl_ovf} !== 6'b0 || tx_data !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_hold: ctl=%b ovf=%b data=%h want all 0", {tx_req, tx_st, tx_end, tx_dwen, cpl_busy}, cpl_ovf, tx_data);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({tx_req, tx_st, tx_end, tx_dwen, cpl_busy, cpl_ovf} !== 6'b0 || tx_data !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_idle: ctl=%b ovf=%b data=%h want all 0", {tx_req, tx_st, tx_end, tx_dwen, cpl_busy}, cpl_ovf, tx_data);
        end
    endtask

    task automatic test_cpld_lo();
        tx_rdy = 1'b1;
        issue(10'd1, 8'hF0, 5'h04, 24'h01002A, 64'h0000_0000_1122_3344, 16'h0200, 3'd0, 2'd0);
        n_cmp++;
        if ({tx_req, tx_st, tx_end, tx_dwen, cpl_busy} !== 5'b10001) begin
            n_bad++; $display("FAIL lo_req ctl: got %b want 10001", {tx_req, tx_st, tx_end, tx_dwen, cpl_busy});
        end
        tick();
        n_cmp++;
        if ({tx_req, tx_st, tx_end, tx_dwen, cpl_busy} !== 5'b11001 || tx_data !== 64'h4A00_0001_0200_0004) begin
            n_bad++; $display("FAIL lo_beat0: ctl=%b data=%h want 11001 4a00000102000004", {tx_req, tx_st, tx_end, tx_dwen, cpl_busy}, tx_data);
        end
        tick();
        n_cmp++;
        if ({tx_req, tx_st, tx_end, tx_dwen, cpl_busy} !== 5'b00101 || tx_data !== 64'h0100_2A10_4433_2211) begin
            n_bad++; $display("FAIL lo_beat1: ctl=%b data=%h want 00101 01002a1044332211", {tx_req, tx_st, tx_end, tx_dwen, cpl_busy}, tx_data);
        end
        tick();
        n_cmp++;
        if ({tx_req, tx_st, tx_end, tx_dwen, cpl_busy} !== 5'b00000 || tx_data !== 64'h0) begin
            n_bad++; $display("FAIL lo_done: ctl=%b data=%h want 00000 0", {tx_req, tx_st, tx_end, tx_dwen, cpl_busy}, tx_data);
        end
    endtask

    task automatic test_cpld_hi();
        // New request lands in the first idle cycle after the previous TLP.
        issue(10'd1, 8'h60, 5'h01, 24'h01002A, 64'hAABB_CCDD_0000_0000, 16'h0200, 3'd0, 2'd0);
        tick();
        n_cmp++;
        if (tx_st !== 1'b1 || tx_data !== 64'h4A00_0001_0200_0002) begin
            n_bad++; $display("FAIL hi_beat0: st=%b data=%h want 1 4a00000102000002", tx_st, tx_data);
        end
        tick();
        n_cmp++;
        if (tx_end !== 1'b1 || tx_dwen !== 1'b0 || tx_data !== 64'h0100_2A05_DDCC_BBAA) begin
            n_bad++; $display("FAIL hi_beat1: end=%b dwen=%b data=%h want 1 0 01002a05ddccbbaa", tx_end, tx_dwen, tx_data);
        end
        tick();
    endtask

    task automatic test_ur();
        issue(10'd2, 8'hF0, 5'h04, 24'h01002A, 64'h1234_5678_9ABC_DEF0, 16'h0200, 3'b101, 2'b10);
        tick();
        n_cmp++;
        if (tx_st !== 1'b1 || tx_data !== 64'h0A50_2000_0200_2004) begin
            n_bad++; $display("FAIL ur_beat0: st=%b data=%h want 1 0a50200002002004", tx_st, tx_data);
        end
        tick();
        n_cmp++;
        if (tx_end !== 1'b1 || tx_dwen !== 1'b1 || tx_data !== 64'h0100_2A10_0000_0000) begin
            n_bad++; $display("FAIL ur_beat1: end=%b dwen=%b data=%h want 1 1 01002a1000000000", tx_end, tx_dwen, tx_data);
        end
        tick();
        n_cmp++;
        if (tx_dwen !== 1'b0 || cpl_busy !== 1'b0) begin
            n_bad++; $display("FAIL ur_done: dwen=%b busy=%b want 0 0", tx_dwen, cpl_busy);
        end
    endtask

    task automatic test_stall();
        int st0, en0;
        int bad_hold;
        st0 = st_cnt; en0 = end_cnt; bad_hold = 0;
        tx_rdy = 1'b0;
        issue(10'd1, 8'h8F, 5'h02, 24'hABCDEF, 64'h5566_7788_99AA_BBCC, 16'h1234, 3'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            if (tx_req !== 1'b1 || tx_st !== 1'b0 || tx_end !== 1'b0) bad_hold++;
            tick();
        end
        tx_rdy = 1'b1;
        tick();
        tx_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (tx_req !== 1'b1 || tx_st !== 1'b1 || tx_end !== 1'b0 || tx_data !== 64'h4A00_0001_1234_0001) bad_hold++;
            tick();
        end
        tx_rdy = 1'b1;
        tick();
        tx_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (tx_req !== 1'b0 || tx_st !== 1'b0 || tx_end !== 1'b1 || tx_data !== 64'hABCD_EF0B_CCBB_AA99) bad_hold++;
            tick();
        end
        tx_rdy = 1'b1;
        tick();
        n_cmp++;
        if (bad_hold !== 0) begin
            n_bad++; $display("FAIL stall_hold: %0d unstable cycles, want 0", bad_hold);
        end
        n_cmp++;
        if (st_cnt - st0 !== 1 || end_cnt - en0 !== 1) begin
            n_bad++; $display("FAIL stall_once: st=%0d end=%0d want 1 1", st_cnt - st0, end_cnt - en0);
        end
        n_cmp++;
        if (cpl_busy !== 1'b0 || tx_end !== 1'b0) begin
            n_bad++; $display("FAIL stall_done: busy=%b end=%b want 0 0", cpl_busy, tx_end);
        end
    endtask

    task automatic test_ovf_in_last();
        int st0;
        int extra_req;
        st0 = st_cnt; extra_req = 0;
        n_cmp++;
        if (cpl_ovf !== 1'b0) begin
            n_bad++; $display("FAIL ovf_pre: got %b want 0", cpl_ovf);
        end
        tx_rdy = 1'b1;
        issue(10'd1, 8'hF0, 5'h04, 24'h01002A, 64'h0000_0000_1122_3344, 16'h0200, 3'd0, 2'd0);
        tick();
        tick();
        // Second request arrives in LAST, exactly as the block heads back to IDLE.
        issue(10'd2, 8'h10, 5'h1F, 24'hFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 3'd7, 2'd3);
        n_cmp++;
        if (cpl_ovf !== 1'b1 || cpl_busy !== 1'b0) begin
            n_bad++; $display("FAIL ovf_set: ovf=%b busy=%b want 1 0", cpl_ovf, cpl_busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (tx_req !== 1'b0 || cpl_busy !== 1'b0) extra_req++;
            tick();
        end
        n_cmp++;
        if (extra_req !== 0 || st_cnt - st0 !== 1 || cpl_ovf !== 1'b1) begin
            n_bad++; $display("FAIL ovf_drop: busy_cycles=%0d tlps=%0d ovf=%b want 0 1 1", extra_req, st_cnt - st0, cpl_ovf);
        end
    endtask

    task automatic test_reset_mid();
        tx_rdy = 1'b1;
        issue(10'd1, 8'h60, 5'h01, 24'h01002A, 64'hAABB_CCDD_0000_0000, 16'h0200, 3'd0, 2'd0);
        tick();
        n_cmp++;
        if (tx_st !== 1'b1) begin
            n_bad++; $display("FAIL rmid_in_hdr: st=%b want 1", tx_st);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx_req, tx_st, tx_end, tx_dwen, cpl_busy, cpl_ovf} !== 6'b0 || tx_data !== 64'h0) begin
            n_bad++; $display("FAIL rmid_clear: ctl=%b ovf=%b data=%h want all 0", {tx_req, tx_st, tx_end, tx_dwen, cpl_busy}, cpl_ovf, tx_data);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (tx_req !== 1'b0 || cpl_busy !== 1'b0) begin
            n_bad++; $display("FAIL rmid_noresume: req=%b busy=%b want 0 0", tx_req, cpl_busy);
        end
        issue(10'd1, 8'hF0, 5'h04, 24'h01002A, 64'h0000_0000_1122_3344, 16'h0200, 3'd0, 2'd0);
        tick();
        n_cmp++;
        if (tx_st !== 1'b1 || tx_data !== 64'h4A00_0001_0200_0004) begin
            n_bad++; $display("FAIL rmid_beat0: st=%b data=%h want 1 4a00000102000004", tx_st, tx_data);
        end
        tick();
        n_cmp++;
        if (tx_end !== 1'b1 || tx_dwen !== 1'b0 || tx_data !== 64'h0100_2A10_4433_2211) begin
            n_bad++; $display("FAIL rmid_beat1: end=%b dwen=%b data=%h want 1 0 01002a1044332211", tx_end, tx_dwen, tx_data);
        end
        tick();
        n_cmp++;
        if (cpl_busy !== 1'b0 || cpl_ovf !== 1'b0) begin
            n_bad++; $display("FAIL rmid_done: busy=%b ovf=%b want 0 0", cpl_busy, cpl_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_cpld_lo();
        test_cpld_hi();
        test_ur();
        test_stall();
        test_ovf_in_last();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
